// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer and msip software
// interrupt bit behind a 32-bit memory-mapped slave port with one-cycle ack.
module clint #(
   parameter int PRESCALE = 1,
   parameter int XLEN     = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req,
   input  logic            i_we,
   input  logic [15:0]     i_addr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [3:0]      i_be,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_ack,
   output logic            o_mtip,
   output logic            o_msip
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [15:0] ADDR_MSIP     = 16'h0000;
   localparam logic [15:0] ADDR_MTCMP_LO = 16'h4000;
   localparam logic [15:0] ADDR_MTCMP_HI = 16'h4004;
   localparam logic [15:0] ADDR_MTIME_LO = 16'hBFF8;
   localparam logic [15:0] ADDR_MTIME_HI = 16'hBFFC;

   logic [PW-1:0]     r_pre;
   logic [2*XLEN-1:0] r_mtime;
   logic [2*XLEN-1:0] r_mtimecmp;
   logic              r_msip;
   logic              r_mtip;
   logic              r_ack;
   logic [XLEN-1:0]   r_rdata;

   logic [15:0]       w_word;
   logic              w_wr;
   logic              w_rd;
   logic              w_tick;
   logic              w_wr_mtime_lo;
   logic              w_wr_mtime_hi;
   logic              w_wr_cmp_lo;
   logic              w_wr_cmp_hi;
   logic              w_wr_msip;
   logic [2*XLEN-1:0] w_mtime_nxt;
   logic [XLEN-1:0]   w_rdata_mux;

   // Replace the byte lanes selected by be with the matching lanes of wd.
   function automatic logic [XLEN-1:0] f_merge(input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] wd,
                                               input logic [3:0]      be);
      f_merge = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) f_merge[8*b +: 8] = wd[8*b +: 8];
      end
   endfunction

   // Low address bits are masked off so every access is word-aligned.
   assign w_word = i_addr & 16'hFFFC;
   assign w_wr   = i_req & i_we;
   assign w_rd   = i_req & ~i_we;
   assign w_tick = (r_pre == PW'(PRESCALE - 1));

   assign w_wr_msip     = w_wr && (w_word == ADDR_MSIP);
   assign w_wr_cmp_lo   = w_wr && (w_word == ADDR_MTCMP_LO);
   assign w_wr_cmp_hi   = w_wr && (w_word == ADDR_MTCMP_HI);
   assign w_wr_mtime_lo = w_wr && (w_word == ADDR_MTIME_LO);
   assign w_wr_mtime_hi = w_wr && (w_word == ADDR_MTIME_HI);

   // Next mtime: a software write wins over the tick and suppresses that increment.
   always_comb begin
      // NOTE: default assigned first so no path through this block infers a latch.
      w_mtime_nxt = r_mtime;
      if (w_wr_mtime_lo || w_wr_mtime_hi) begin
         if (w_wr_mtime_lo) w_mtime_nxt[XLEN-1:0]      = f_merge(r_mtime[XLEN-1:0], i_wdata, i_be);
         if (w_wr_mtime_hi) w_mtime_nxt[2*XLEN-1:XLEN] = f_merge(r_mtime[2*XLEN-1:XLEN], i_wdata, i_be);
      end else if (w_tick) begin
         w_mtime_nxt = r_mtime + 1'b1;
      end
   end

   // Read mux over the register map; unmapped offsets read as zero.
   always_comb begin
      w_rdata_mux = '0;
      case (w_word)
         ADDR_MSIP:     w_rdata_mux = {{(XLEN-1){1'b0}}, r_msip};
         ADDR_MTCMP_LO: w_rdata_mux = r_mtimecmp[XLEN-1:0];
         ADDR_MTCMP_HI: w_rdata_mux = r_mtimecmp[2*XLEN-1:XLEN];
         ADDR_MTIME_LO: w_rdata_mux = r_mtime[XLEN-1:0];
         ADDR_MTIME_HI: w_rdata_mux = r_mtime[2*XLEN-1:XLEN];
         default:       w_rdata_mux = '0;
      endcase
   end

   // Prescaler, timer, compare, software bit and bus response registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      // NOTE: every register here is a plain flop with a defined reset value;
      // there is no storage array, so nothing is left uninitialised.
      if (!i_rst) begin
         r_pre      <= '0;
         r_mtime    <= '0;
         r_mtimecmp <= '1;
         r_msip     <= 1'b0;
         r_mtip     <= 1'b0;
         r_ack      <= 1'b0;
         r_rdata    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values,
         // e.g. the compare below uses mtime/mtimecmp from before this edge.
         r_pre   <= w_tick ? '0 : r_pre + PW'(1);
         r_mtime <= w_mtime_nxt;
         r_mtip  <= (r_mtime >= r_mtimecmp);
         r_ack   <= i_req;
         if (w_wr_cmp_lo) r_mtimecmp[XLEN-1:0]      <= f_merge(r_mtimecmp[XLEN-1:0], i_wdata, i_be);
         if (w_wr_cmp_hi) r_mtimecmp[2*XLEN-1:XLEN] <= f_merge(r_mtimecmp[2*XLEN-1:XLEN], i_wdata, i_be);
         if (w_wr_msip && i_be[0]) r_msip <= i_wdata[0];
         if (w_rd) r_rdata <= w_rdata_mux;
      end
   end

   assign o_rdata = r_rdata;
   assign o_ack   = r_ack;
   assign o_mtip  = r_mtip;
   assign o_msip  = r_msip;

endmodule
